vedacao_multi: RTL and testbench
================================

VEDACAO_MULTI -- requirements
Module: vedacao_multi

Interface
REQ-001 Parameter ROLHA_W, default 4: cork magazine counter width.
REQ-002 Parameter ROLHA_CAP, default 12: magazine count after refill; SHALL be at least 1 and no more than 2^ROLHA_W-1.
REQ-003 Parameter SEAL_CYC, default 3: clock cycles the sealer stays actuated; SHALL be at least 1.
REQ-004 Parameter LOW_THR, default 2: low-stock warning threshold.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 garrafa  in  1  bottle present at the sealing station.
REQ-008 pos  in  1  bottle aligned under the sealer.
REQ-009 recarga  in  1  magazine refilled; sampled as a level each cycle.
REQ-010 ack  in  1  operator alarm acknowledge.
REQ-011 ve  out  1  sealer actuator.
REQ-012 done  out  1  one-cycle pulse when a seal completes.
REQ-013 alarme  out  1  alarm active.
REQ-014 causa  out  2  alarm cause: 00 none, 01 magazine empty, 10 misalignment.
REQ-015 rolhas  out  ROLHA_W  corks remaining.
REQ-016 baixo  out  1  high when rolhas is at or below LOW_THR and nonzero.

Function
REQ-017 The FSM SHALL have states IDLE, SEAL, DONE, WREM and ALARM, with registered state and combinational next-state logic.
REQ-018 IDLE: rolhas==0 goes to ALARM with causa=01; otherwise garrafa&pos goes to SEAL and clears the dwell timer; otherwise the FSM stays in IDLE.
REQ-019 SEAL: ve=1; pos==0 or garrafa==0 goes to ALARM with causa=10; otherwise the timer increments, and on the cycle the timer equals SEAL_CYC-1 the FSM goes to DONE.
REQ-020 From SEAL entry, ve SHALL be high for exactly SEAL_CYC consecutive cycles, followed by done for 1 cycle.
REQ-021 DONE: done=1 and ve=0 for exactly one cycle; rolhas decrements by 1 on exit; next state is WREM.
REQ-022 WREM: stays until garrafa==0, then goes to IDLE; this prevents a bottle being sealed twice.
REQ-023 ALARM: alarme=1 and causa is held.
REQ-024 ALARM with ack=1 and rolhas!=0 goes to WREM when garrafa==1, else to IDLE.
REQ-025 ALARM with ack=1 while rolhas==0 stays in ALARM.
REQ-026 causa SHALL be 00 in every state other than ALARM.
REQ-027 recarga=1 SHALL load rolhas with ROLHA_CAP in any state on the next edge.
REQ-028 If recarga and the DONE decrement coincide, the refill SHALL win and the result is ROLHA_CAP.
REQ-029 rolhas SHALL never wrap below 0: the decrement is enabled only in DONE, and DONE is unreachable with rolhas==0.
REQ-030 ve, done and alarme SHALL be mutually exclusive in every cycle.
REQ-031 Illegal state encodings SHALL go to IDLE on the next edge.

Reset
REQ-032 reset=0 SHALL immediately force state=IDLE, timer=0, rolhas=ROLHA_CAP, ve=0, done=0, alarme=0, causa=00, and baixo=0 when ROLHA_CAP>LOW_THR.
REQ-033 Reset asserted mid-SEAL SHALL drop ve asynchronously and SHALL NOT decrement rolhas.
REQ-034 The FSM SHALL leave IDLE on the first rising edge after reset deasserts if its conditions hold.

Configuration
REQ-035 With macro VEDACAO_CONTADOR_EN defined, the module SHALL add output total [15:0], reset to 0, incremented on each DONE cycle and wrapping from 65535 to 0.
REQ-036 Without VEDACAO_CONTADOR_EN, total and its register SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-037 Defaults, reset released, garrafa=pos=1 held -> ve high cycles 1-3, done cycle 4, rolhas 12->11, FSM in WREM until garrafa=0.
REQ-038 12 complete bottles -> rolhas reaches 0, baixo high at rolhas=2 and 1, next IDLE cycle -> alarme=1 with causa=01; ack alone keeps ALARM; recarga then ack -> IDLE with rolhas=12.
REQ-039 pos dropped in the 2nd SEAL cycle -> ALARM next edge, causa=10, no done, rolhas unchanged; ack with garrafa=1 -> WREM.
REQ-040 recarga asserted in the DONE cycle with rolhas=5 -> rolhas=12, not 4.
REQ-041 reset pulsed low mid-SEAL -> ve=0 immediately, rolhas=12, state IDLE; with VEDACAO_CONTADOR_EN, total=0.
REQ-042 With VEDACAO_CONTADOR_EN, 3 seals -> total=3; preload 65535 via forced state then 1 seal -> total=0.

Source files
------------

// File: rtl/vedacao_multi.sv
// Cork sealing station controller; VEDACAO_CONTADOR_EN adds the 16-bit sealed-bottle counter output total.
// Latency: seal runs SEAL_CYC actuated cycles, then a one-cycle done; outputs decode registered state.
// Backpressure: none; the station waits in WREM until the bottle leaves and holds ALARM until ack.
module vedacao_multi #(
    parameter int ROLHA_W   = 4,
    parameter int ROLHA_CAP = 12,
    parameter int SEAL_CYC  = 3,
    parameter int LOW_THR   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               garrafa,
    input  logic               pos,
    input  logic               recarga,
    input  logic               ack,
    output logic               ve,
    output logic               done,
    output logic               alarme,
    output logic [1:0]         causa,
    output logic [ROLHA_W-1:0] rolhas,
    output logic               baixo
`ifdef VEDACAO_CONTADOR_EN
    ,
    output logic [15:0]        total
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEAL  = 3'd1,
        S_DONE  = 3'd2,
        S_WREM  = 3'd3,
        S_ALARM = 3'd4
    } state_t;

    localparam int                 TW         = (SEAL_CYC > 1) ? $clog2(SEAL_CYC) : 1;
    localparam logic [TW-1:0]      TIMER_LAST = TW'(SEAL_CYC - 1);
    localparam logic [ROLHA_W-1:0] CAP        = ROLHA_W'(ROLHA_CAP);
    localparam logic [ROLHA_W-1:0] THR        = ROLHA_W'(LOW_THR);
    localparam logic [1:0]         CAUSA_NONE = 2'b00;
    localparam logic [1:0]         CAUSA_VAZIO = 2'b01;
    localparam logic [1:0]         CAUSA_DESAL = 2'b10;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [ROLHA_W-1:0] rolhas_q, rolhas_d;
    logic [1:0]         causa_q, causa_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            rolhas_q <= CAP;
            causa_q  <= CAUSA_NONE;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            rolhas_q <= rolhas_d;
            causa_q  <= causa_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        causa_d = causa_q;
        unique case (state_q)
            S_IDLE: begin
                if (rolhas_q == '0) begin
                    state_d = S_ALARM;
                    causa_d = CAUSA_VAZIO;
                end else if (garrafa && pos) begin
                    state_d = S_SEAL;
                    timer_d = '0;
                end
            end
            S_SEAL: begin
                // Losing the bottle or alignment aborts even on the last actuated cycle.
                if (!pos || !garrafa) begin
                    state_d = S_ALARM;
                    causa_d = CAUSA_DESAL;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: state_d = S_WREM;
            S_WREM: begin
                if (!garrafa) state_d = S_IDLE;
            end
            S_ALARM: begin
                if (ack && rolhas_q != '0) begin
                    state_d = garrafa ? S_WREM : S_IDLE;
                    causa_d = CAUSA_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Refill wins over the DONE decrement; DONE is never reached with an empty magazine.
    always_comb begin
        rolhas_d = rolhas_q;
        if (recarga)                rolhas_d = CAP;
        else if (state_q == S_DONE) rolhas_d = rolhas_q - 1'b1;
    end

    always_comb begin
        ve     = (state_q == S_SEAL);
        done   = (state_q == S_DONE);
        alarme = (state_q == S_ALARM);
        causa  = (state_q == S_ALARM) ? causa_q : CAUSA_NONE;
        rolhas = rolhas_q;
        baixo  = (rolhas_q != '0) && (rolhas_q <= THR);
    end

`ifdef VEDACAO_CONTADOR_EN
    logic [15:0] total_q, total_d;

    always_comb total_d = (state_q == S_DONE) ? total_q + 16'd1 : total_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) total_q <= '0;
        else        total_q <= total_d;
    end

    assign total = total_q;
`endif

endmodule

// File: tb/tb_vedacao_multi.sv
// Self-checking bench for vedacao_multi: directed scenarios plus randomized traffic against a behavioural model.
module tb_vedacao_multi;
    localparam int ROLHA_W   = 4;
    localparam int ROLHA_CAP = 12;
    localparam int SEAL_CYC  = 3;
    localparam int LOW_THR   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic garrafa = 1'b0, pos = 1'b0, recarga = 1'b0, ack = 1'b0;
    logic ve, done, alarme, baixo;
    logic [1:0] causa;
    logic [ROLHA_W-1:0] rolhas;
`ifdef VEDACAO_CONTADOR_EN
    logic [15:0] total;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vedacao_multi #(
        .ROLHA_W(ROLHA_W), .ROLHA_CAP(ROLHA_CAP), .SEAL_CYC(SEAL_CYC), .LOW_THR(LOW_THR)
    ) dut (
        .clk(clk), .reset(reset), .garrafa(garrafa), .pos(pos), .recarga(recarga), .ack(ack),
        .ve(ve), .done(done), .alarme(alarme), .causa(causa), .rolhas(rolhas), .baixo(baixo)
`ifdef VEDACAO_CONTADOR_EN
        , .total(total)
`endif
    );

    task automatic drive(input logic g, input logic p, input logic r, input logic a);
        garrafa = g; pos = p; recarga = r; ack = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // From IDLE: bring a bottle, seal it, remove it; ends back in IDLE.
    task automatic seal_bottle();
        drive(1, 1, 0, 0);
        repeat (SEAL_CYC + 2) tick();
        drive(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0);
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (ve !== 1'b0)     begin n_fail++; $display("FAIL rst_ve got=%0b exp=0", ve); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL rst_done got=%0b exp=0", done); end
        n_checks++; if (alarme !== 1'b0) begin n_fail++; $display("FAIL rst_alarme got=%0b exp=0", alarme); end
        n_checks++; if (causa !== 2'b00) begin n_fail++; $display("FAIL rst_causa got=%0b exp=00", causa); end
        n_checks++; if (rolhas !== 4'd12) begin n_fail++; $display("FAIL rst_rolhas got=%0d exp=12", rolhas); end
        n_checks++; if (baixo !== 1'b0)  begin n_fail++; $display("FAIL rst_baixo got=%0b exp=0", baixo); end
`ifdef VEDACAO_CONTADOR_EN
        n_checks++; if (total !== 16'd0) begin n_fail++; $display("FAIL rst_total got=%0d exp=0", total); end
`endif
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (ve !== 1'b0 || alarme !== 1'b0) begin n_fail++; $display("FAIL rst_idle ve=%0b alarme=%0b exp=0,0", ve, alarme); end
    endtask

    task automatic test_single_seal();
        apply_reset();
        drive(1, 1, 0, 0);
        for (int c = 1; c <= SEAL_CYC + 1; c++) begin
            logic exp_ve, exp_done;
            tick();
            exp_ve   = (c <= SEAL_CYC);
            exp_done = (c == SEAL_CYC + 1);
            n_checks++; if (ve !== exp_ve)     begin n_fail++; $display("FAIL seal_ve cyc=%0d got=%0b exp=%0b", c, ve, exp_ve); end
            n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL seal_done cyc=%0d got=%0b exp=%0b", c, done, exp_done); end
            n_checks++; if (rolhas !== 4'd12)  begin n_fail++; $display("FAIL seal_rolhas_hold cyc=%0d got=%0d exp=12", c, rolhas); end
        end
        tick();
        n_checks++; if (rolhas !== 4'd11) begin n_fail++; $display("FAIL seal_rolhas_dec got=%0d exp=11", rolhas); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (ve !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL wrem_hold cyc=%0d ve=%0b done=%0b exp=0,0", c, ve, done); end
        end
        drive(0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0);
        tick();
        n_checks++; if (ve !== 1'b1) begin n_fail++; $display("FAIL wrem_release_ve got=%0b exp=1", ve); end
        repeat (SEAL_CYC + 1) tick();
        drive(0, 0, 0, 0);
        tick();
        n_checks++; if (rolhas !== 4'd10) begin n_fail++; $display("FAIL second_seal_rolhas got=%0d exp=10", rolhas); end
    endtask

    task automatic test_empty_magazine();
        apply_reset();
        for (int k = 1; k <= ROLHA_CAP; k++) begin
            int  exp_r;
            logic exp_b;
            seal_bottle();
            exp_r = ROLHA_CAP - k;
            exp_b = (exp_r != 0) && (exp_r <= LOW_THR);
            n_checks++; if (rolhas !== exp_r[ROLHA_W-1:0]) begin n_fail++; $display("FAIL empty_rolhas k=%0d got=%0d exp=%0d", k, rolhas, exp_r); end
            n_checks++; if (baixo !== exp_b) begin n_fail++; $display("FAIL empty_baixo k=%0d got=%0b exp=%0b", k, baixo, exp_b); end
        end
        tick();
        n_checks++; if (alarme !== 1'b1) begin n_fail++; $display("FAIL empty_alarme got=%0b exp=1", alarme); end
        n_checks++; if (causa !== 2'b01) begin n_fail++; $display("FAIL empty_causa got=%0b exp=01", causa); end
        drive(0, 0, 0, 1);
        tick();
        n_checks++; if (alarme !== 1'b1 || causa !== 2'b01) begin n_fail++; $display("FAIL empty_ack_only alarme=%0b causa=%0b exp=1,01", alarme, causa); end
        drive(0, 0, 1, 0);
        tick();
        n_checks++; if (rolhas !== 4'd12) begin n_fail++; $display("FAIL empty_refill got=%0d exp=12", rolhas); end
        n_checks++; if (alarme !== 1'b1)  begin n_fail++; $display("FAIL empty_refill_alarme got=%0b exp=1", alarme); end
        drive(0, 0, 0, 1);
        tick();
        n_checks++; if (alarme !== 1'b0 || causa !== 2'b00) begin n_fail++; $display("FAIL empty_cleared alarme=%0b causa=%0b exp=0,00", alarme, causa); end
        drive(1, 1, 0, 0);
        tick();
        n_checks++; if (ve !== 1'b1) begin n_fail++; $display("FAIL empty_idle_reseal got=%0b exp=1", ve); end
        drive(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_misalign();
        apply_reset();
        drive(1, 1, 0, 0);
        tick();
        tick();
        n_checks++; if (ve !== 1'b1) begin n_fail++; $display("FAIL mis_ve2 got=%0b exp=1", ve); end
        drive(1, 0, 0, 0);
        tick();
        n_checks++; if (alarme !== 1'b1 || causa !== 2'b10) begin n_fail++; $display("FAIL mis_alarm alarme=%0b causa=%0b exp=1,10", alarme, causa); end
        n_checks++; if (ve !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mis_outputs ve=%0b done=%0b exp=0,0", ve, done); end
        tick();
        n_checks++; if (done !== 1'b0 || alarme !== 1'b1) begin n_fail++; $display("FAIL mis_hold done=%0b alarme=%0b exp=0,1", done, alarme); end
        n_checks++; if (rolhas !== 4'd12) begin n_fail++; $display("FAIL mis_rolhas got=%0d exp=12", rolhas); end
        drive(1, 0, 0, 1);
        tick();
        n_checks++; if (alarme !== 1'b0 || causa !== 2'b00) begin n_fail++; $display("FAIL mis_ack alarme=%0b causa=%0b exp=0,00", alarme, causa); end
        drive(1, 1, 0, 0);
        tick();
        tick();
        n_checks++; if (ve !== 1'b0) begin n_fail++; $display("FAIL mis_wrem got_ve=%0b exp=0", ve); end
        drive(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_refill_in_done();
        apply_reset();
        repeat (7) seal_bottle();
        n_checks++; if (rolhas !== 4'd5) begin n_fail++; $display("FAIL refill_pre got=%0d exp=5", rolhas); end
        drive(1, 1, 0, 0);
        repeat (SEAL_CYC + 1) tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL refill_done got=%0b exp=1", done); end
        drive(1, 1, 1, 0);
        tick();
        n_checks++; if (rolhas !== 4'd12) begin n_fail++; $display("FAIL refill_wins got=%0d exp=12", rolhas); end
        drive(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid_seal();
        apply_reset();
        seal_bottle();
        drive(1, 1, 0, 0);
        tick();
        tick();
        n_checks++; if (ve !== 1'b1) begin n_fail++; $display("FAIL rms_pre_ve got=%0b exp=1", ve); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (ve !== 1'b0) begin n_fail++; $display("FAIL rms_ve_async got=%0b exp=0", ve); end
        n_checks++; if (rolhas !== 4'd12) begin n_fail++; $display("FAIL rms_rolhas got=%0d exp=12", rolhas); end
`ifdef VEDACAO_CONTADOR_EN
        n_checks++; if (total !== 16'd0) begin n_fail++; $display("FAIL rms_total got=%0d exp=0", total); end
`endif
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (ve !== 1'b1) begin n_fail++; $display("FAIL rms_first_edge got=%0b exp=1", ve); end
        repeat (SEAL_CYC + 1) tick();
        drive(0, 0, 0, 0);
        tick();
    endtask

`ifdef VEDACAO_CONTADOR_EN
    task automatic test_counter();
        apply_reset();
        repeat (3) seal_bottle();
        n_checks++; if (total !== 16'd3) begin n_fail++; $display("FAIL cnt_three got=%0d exp=3", total); end
        force dut.total_q = 16'hFFFF;
        tick();
        release dut.total_q;
        seal_bottle();
        n_checks++; if (total !== 16'd0) begin n_fail++; $display("FAIL cnt_wrap got=%0d exp=0", total); end
    endtask
`endif

    // Behavioural model: the station as a sequence of phases with a countdown of actuated cycles.
    task automatic test_random();
        localparam int M_WAIT = 0, M_SEALING = 1, M_PULSE = 2, M_REMOVE = 3, M_ALARM = 4;
        int m_mode, m_left, m_corks, m_cause, next_corks;
        logic g, p, r, a;
        logic e_ve, e_done, e_al, e_b;
        logic [1:0] e_causa;
        apply_reset();
        m_mode = M_WAIT; m_left = 0; m_corks = ROLHA_CAP; m_cause = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            g = ($urandom_range(0, 5) != 0);
            p = ($urandom_range(0, 7) != 0);
            r = ($urandom_range(0, 59) == 0);
            a = ($urandom_range(0, 3) == 0);
            drive(g, p, r, a);
            next_corks = r ? ROLHA_CAP : ((m_mode == M_PULSE) ? m_corks - 1 : m_corks);
            case (m_mode)
                M_WAIT:    if (m_corks == 0) begin m_mode = M_ALARM; m_cause = 1; end
                           else if (g && p) begin m_mode = M_SEALING; m_left = SEAL_CYC; end
                M_SEALING: if (!g || !p) begin m_mode = M_ALARM; m_cause = 2; end
                           else begin m_left--; if (m_left == 0) m_mode = M_PULSE; end
                M_PULSE:   m_mode = M_REMOVE;
                M_REMOVE:  if (!g) m_mode = M_WAIT;
                default:   if (a && m_corks != 0) m_mode = g ? M_REMOVE : M_WAIT;
            endcase
            m_corks = next_corks;
            tick();
            e_ve    = (m_mode == M_SEALING);
            e_done  = (m_mode == M_PULSE);
            e_al    = (m_mode == M_ALARM);
            e_causa = e_al ? m_cause[1:0] : 2'b00;
            e_b     = (m_corks != 0) && (m_corks <= LOW_THR);
            n_checks++; if (ve !== e_ve)         begin n_fail++; $display("FAIL rnd_ve cyc=%0d got=%0b exp=%0b", cyc, ve, e_ve); end
            n_checks++; if (done !== e_done)     begin n_fail++; $display("FAIL rnd_done cyc=%0d got=%0b exp=%0b", cyc, done, e_done); end
            n_checks++; if (alarme !== e_al)     begin n_fail++; $display("FAIL rnd_alarme cyc=%0d got=%0b exp=%0b", cyc, alarme, e_al); end
            n_checks++; if (causa !== e_causa)   begin n_fail++; $display("FAIL rnd_causa cyc=%0d got=%0b exp=%0b", cyc, causa, e_causa); end
            n_checks++; if (rolhas !== m_corks[ROLHA_W-1:0]) begin n_fail++; $display("FAIL rnd_rolhas cyc=%0d got=%0d exp=%0d", cyc, rolhas, m_corks); end
            n_checks++; if (baixo !== e_b)       begin n_fail++; $display("FAIL rnd_baixo cyc=%0d got=%0b exp=%0b", cyc, baixo, e_b); end
            n_checks++; if ((32'(ve) + 32'(done) + 32'(alarme)) > 1) begin n_fail++; $display("FAIL rnd_exclusive cyc=%0d ve=%0b done=%0b alarme=%0b exp=at most one", cyc, ve, done, alarme); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_seal();
        test_empty_magazine();
        test_misalign();
        test_refill_in_done();
        test_reset_mid_seal();
`ifdef VEDACAO_CONTADOR_EN
        test_counter();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
